seg_scan_pwm: RTL
=================

# seg_scan_pwm

Multiplexed digit scanner with per-slot PWM dimming, sitting directly downstream of the per-digit 7-segment decoders. It takes the packed segment patterns of all digits (a..g, dp per digit) and time-multiplexes them onto one shared segment bus plus one-hot digit enables. Brightness is set by a PWM duty within each digit slot, and a dead-time guard precedes every lit window to suppress ghosting.

## Interface
- DIGITS, 4: number of scanned digits, legal 1..8.
- PRESCALE, 64: clk cycles per PWM step, legal ≥1.
- GUARD, 4: dark PWM steps at the start of each slot, legal 0..255.
- SEG_INV, 0: 1 = segment outputs active-low.
- DIG_INV, 0: 1 = digit enables active-low.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  8*DIGITS  packed patterns; digit k occupies [8k+7:8k], bit0=a … bit6=g, bit7=dp, 1 = segment lit.
- brightness  in  8  PWM duty in steps per slot, 0 = dark.
- blank  in  1  synchronous global blank, forces all outputs inactive.
- seg_out  out  8  shared segment bus, same bit order as seg_in, polarity per SEG_INV.
- dig_en  out  DIGITS  one-hot digit enable, polarity per DIG_INV.
- frame_tick  out  1  one-clock pulse per completed scan frame.

## Operation
- Counters: presc (0..PRESCALE-1), step (8 bit, 0..255), digit_idx (0..DIGITS-1).
- FSM with two states:
  - S_LOAD, exactly one clock: seg_lat <= seg_in slice for digit_idx; bright_lat <= brightness; presc <= 0; step <= 0; next state S_RUN.
  - S_RUN: presc increments every clock. On presc==PRESCALE-1, presc wraps to 0 and step increments. When presc==PRESCALE-1 and step==255, digit_idx advances (DIGITS-1 wraps to 0) and the next state is S_LOAD.
- Slot length is 1 + 256*PRESCALE clocks. Frame length is DIGITS * slot length.
- lit = (state==S_RUN) && (step ≥ GUARD) && (step − GUARD < bright_lat) && !blank. Compare is 9-bit unsigned, so there is no wrap.
- Duty saturates. The lit window is min(bright_lat, 256−GUARD) steps.
- Active-level outputs: seg_out = lit ? seg_lat : 0; dig_en = lit ? (1<<digit_idx) : 0. Inversions are then applied per SEG_INV / DIG_INV.
- A pattern of seg_lat==0 still drives dig_en during lit. The enable is not gated by the pattern.
- seg_in and brightness changes mid-slot have no effect until the next S_LOAD.
- blank affects outputs only. Counters, FSM and frame_tick keep running.
- frame_tick pulses on the clock in which digit_idx wraps DIGITS-1 → 0.

## Timing
- seg_out, dig_en and frame_tick are registered and reflect lit / counter state with one clock of latency.
- Reset values (rst_n low, asynchronous):
  - state=S_LOAD; presc=0; step=0; digit_idx=0; seg_lat=0; bright_lat=0.
  - seg_out=SEG_INV?8'hFF:8'h00; dig_en=DIG_INV?all-ones:0; frame_tick=0.
- After reset release, the first clock is S_LOAD for digit 0.
- Lit window within a slot: with L = the S_LOAD clock, step s begins at clock L+1+s*PRESCALE. The outputs go active at L+2+GUARD*PRESCALE and stay active for min(bright_lat,256−GUARD)*PRESCALE consecutive clocks.
- Outputs are always inactive during S_LOAD and during the guard steps, so consecutive digits never overlap.
- blank asserted in clock n: outputs are inactive from clock n+1. After deassertion, outputs resume per lit at the next clock, in the same slot.
- Reset asserted mid-slot: all outputs go to their inactive levels immediately (asynchronous). The scan restarts at digit 0.

## Test plan
- Reset, with DIGITS=4, PRESCALE=1, GUARD=4 (used for all tests): hold rst_n low, then release -> seg_out=0, dig_en=0, frame_tick=0 during reset; first S_LOAD on the clock after release.
- brightness=0, seg_in all 8'hFF -> dig_en stays 0 for a full frame; frame_tick pulses every 1028 clocks.
- brightness=100, digit2 = 8'h3F -> in digit 2's slot, dig_en=4'b0100 and seg_out=8'h3F for exactly 100 clocks, starting 6 clocks after that slot's S_LOAD.
- brightness=255 -> lit window saturates at exactly 252 clocks per slot. Changing brightness to 10 mid-slot leaves the current slot at 252; the next slot is 10.
- blank pulsed for 20 clocks inside a lit window -> outputs inactive for exactly those 20 clocks (shifted +1), then resume; frame_tick period is unchanged.
- SEG_INV=1, DIG_INV=1, with rst_n asserted mid-window -> seg_out=8'hFF and dig_en=4'hF immediately; after release, digit 0 scans first.

Source files
------------

// File: rtl/seg_scan_pwm.sv
// seg_scan_pwm: time-multiplexes the packed 7-segment patterns of DIGITS digits
// onto one shared segment bus with one-hot digit enables. Each digit owns a slot
// of 1 + 256*PRESCALE clocks: one load clock, then 256 PWM steps. The first GUARD
// steps stay dark to suppress ghosting, and the remaining steps are lit for a
// duty of 'brightness' steps. The duty saturates at the end of the slot.
module seg_scan_pwm #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 64,
  parameter int GUARD    = 4,
  parameter bit SEG_INV  = 1'b0,
  parameter bit DIG_INV  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*DIGITS-1:0]   seg_in,
  input  logic [7:0]            brightness,
  input  logic                  blank,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     DIGIT_MAX = DW'(DIGITS - 1);
  localparam logic [8:0]        GUARD9    = 9'(GUARD);
  localparam logic [7:0]        SEG_IDLE  = SEG_INV ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_IDLE  = DIG_INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [7:0]        step_q, step_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [7:0]        seg_lat_q, seg_lat_d;
  logic [7:0]        bright_lat_q, bright_lat_d;
  logic              frame_wrap;

  logic              lit;
  logic [8:0]        step9;
  logic [7:0]        seg_sel;
  logic [DIGITS-1:0] onehot;

  logic [7:0]        seg_out_q, seg_out_d;
  logic [DIGITS-1:0] dig_en_q, dig_en_d;
  logic              frame_tick_q, frame_tick_d;

  // Pattern of the digit about to be loaded, chosen by the current scan index.
  always_comb begin
    seg_sel = 8'h00;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_q == DW'(k)) seg_sel = seg_in[8*k +: 8];
    end
  end

  // Slot sequencing: one load clock, then the prescaled 256-step PWM run.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d      = state_q;
    presc_d      = presc_q;
    step_d       = step_q;
    digit_d      = digit_q;
    seg_lat_d    = seg_lat_q;
    bright_lat_d = bright_lat_q;
    frame_wrap   = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        seg_lat_d    = seg_sel;
        bright_lat_d = brightness;
        presc_d      = '0;
        step_d       = 8'd0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          step_d  = step_q + 8'd1;
          if (step_q == 8'hFF) begin
            state_d = S_LOAD;
            if (digit_q == DIGIT_MAX) begin
              digit_d    = '0;
              frame_wrap = 1'b1;
            end else begin
              digit_d = digit_q + DW'(1);
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Lit window: past the guard steps and inside the duty, compared 9-bit so
  // that step - GUARD never wraps and a duty beyond the slot simply saturates.
  always_comb begin
    step9 = {1'b0, step_q};
    lit   = (state_q == S_RUN) && (step9 >= GUARD9) &&
            ((step9 - GUARD9) < {1'b0, bright_lat_q}) && !blank;
    for (int k = 0; k < DIGITS; k++) begin
      onehot[k] = (digit_q == DW'(k));
    end
    seg_out_d    = (lit ? seg_lat_q : 8'h00) ^ SEG_IDLE;
    dig_en_d     = (lit ? onehot : {DIGITS{1'b0}}) ^ DIG_IDLE;
    frame_tick_d = frame_wrap;
  end

  // Scan state, counters and per-slot latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      presc_q      <= '0;
      step_q       <= 8'd0;
      digit_q      <= '0;
      // NOTE: the pattern/duty latches are reset too; they are only two bytes
      // and a defined value keeps the first load clock free of X.
      seg_lat_q    <= 8'h00;
      bright_lat_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      presc_q      <= presc_d;
      step_q       <= step_d;
      digit_q      <= digit_d;
      seg_lat_q    <= seg_lat_d;
      bright_lat_q <= bright_lat_d;
    end
  end

  // Registered outputs; reset drives them to their inactive polarity at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out_q    <= SEG_IDLE;
      dig_en_q     <= DIG_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      seg_out_q    <= seg_out_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule
